// File: rtl/cmp_scheduler.sv
// cmp_scheduler: round-robin arbiter sharing one 4-bit comparator among NREQ requesters; define CMP_SCHED_STATS_EN for saturating grant counters
module cmp_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*4-1:0] req_x,
    input  logic [NREQ*4-1:0] req_y,
    input  logic [NREQ*2-1:0] req_s,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_data,
    output logic [NREQ*8-1:0] stat_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         r_state, w_next;
    logic [IDW-1:0] r_last, w_win;
    logic           w_found, w_accept;
    logic [3:0]     r_x, r_y;
    logic [1:0]     r_s;
    logic [IDW-1:0] r_id;
    logic [7:0]     r_data, w_res;

    // round-robin search starting just after the last winner
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NREQ; k++)
            if (!w_found && req_valid[(int'(r_last) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(r_last) + k) % NREQ);
            end
    end

    assign w_accept  = (r_state == IDLE) && w_found;
    assign req_ready = (rst_n && w_accept) ? NREQ'(1) << w_win : '0;
    assign rsp_valid = (r_state == RESP);
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;

    // comparison on the registered operands, all unsigned
    always_comb begin
        w_res = (r_s == 2'b00) ? {7'b0, r_x == r_y} :
                (r_s == 2'b01) ? {7'b0, r_x > r_y}  :
                (r_s == 2'b10) ? {7'b0, r_x < r_y}  :
                                 {4'b0, (r_x > r_y) ? r_x : r_y};
    end

    // next state: one cycle to accept, one to compute, hold response until taken
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_found ? EXEC : IDLE;
            EXEC:    w_next = RESP;
            RESP:    w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // state register, grant pointer, operand capture and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= IDW'(NREQ - 1);
            r_x     <= '0;
            r_y     <= '0;
            r_s     <= '0;
            r_id    <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_last <= w_win;
                r_x    <= req_x[w_win*4 +: 4];
                r_y    <= req_y[w_win*4 +: 4];
                r_s    <= req_s[w_win*2 +: 2];
            end
            if (r_state == EXEC) begin
                r_data <= w_res;
                r_id   <= r_last;
            end
        end
    end

`ifdef CMP_SCHED_STATS_EN
    logic [NREQ*8-1:0] r_cnt;

    // per-requester accept counters that stick at 8'hFF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_accept)
            r_cnt[w_win*8 +: 8] <= r_cnt[w_win*8 +: 8] + {7'b0, r_cnt[w_win*8 +: 8] != 8'hFF};
    end

    assign stat_cnt = r_cnt;
`else
    assign stat_cnt = '0;
`endif
endmodule

// File: tb/tb_cmp_scheduler.sv
// tb_cmp_scheduler: randomized and directed checks of cmp_scheduler against a transaction-level model
module tb_cmp_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_x = '0, req_y = '0;
    logic [7:0]  req_s = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic [31:0] stat_cnt;

    int n_cmp = 0, n_bad = 0;
    int m_last = 3;
    int m_cnt[4] = '{0, 0, 0, 0};

    cmp_scheduler #(.NREQ(4), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_s(req_s), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .stat_cnt(stat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_op(input int x, input int y, input int s);
        if (s == 0) return (x == y) ? 8'd1 : 8'd0;
        if (s == 1) return (x > y) ? 8'd1 : 8'd0;
        if (s == 2) return (x < y) ? 8'd1 : 8'd0;
        return 8'((x > y) ? x : y);
    endfunction

    function automatic int ref_win(input logic [3:0] v);
        for (int k = 1; k <= 4; k++)
            if (v[(m_last + k) % 4]) return (m_last + k) % 4;
        return -1;
    endfunction

    function automatic logic [31:0] ref_stats();
        logic [31:0] r = '0;
`ifdef CMP_SCHED_STATS_EN
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(m_cnt[i]);
`endif
        return r;
    endfunction

    task automatic ref_reset();
        m_last = 3;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        req_valid = 4'($urandom);
        req_x = 16'($urandom);
        req_y = 16'($urandom);
        req_s = 8'($urandom);
    endtask

    // one IDLE cycle plus, if granted, the full transaction with hold cycles of backpressure
    task automatic txn(input logic [3:0] v, input logic [15:0] x, input logic [15:0] y,
                       input logic [7:0] s, input int hold);
        int w;
        logic [7:0] exp;
        req_valid = v; req_x = x; req_y = y; req_s = s; rsp_ready = 1'b0;
        w = ref_win(v);
        @(negedge clk);
        chk("idle_rsp_valid", 32'(rsp_valid), 0);
        chk("grant", 32'(req_ready), (w < 0) ? 0 : 32'(1) << w);
        if (w < 0) begin
            next_cycle();
            return;
        end
        exp = ref_op(int'(x[w*4 +: 4]), int'(y[w*4 +: 4]), int'(s[w*2 +: 2]));
        m_last = w;
        if (m_cnt[w] < 255) m_cnt[w]++;
        next_cycle();
        scramble();
        @(negedge clk);
        chk("exec_ready", 32'(req_ready), 0);
        chk("exec_rsp_valid", 32'(rsp_valid), 0);
        next_cycle();
        for (int h = 0; h <= hold; h++) begin
            rsp_ready = (h == hold);
            if (h > 0) scramble();
            @(negedge clk);
            chk("rsp_valid", 32'(rsp_valid), 1);
            chk("rsp_id", 32'(rsp_id), 32'(w));
            chk("rsp_data", 32'(rsp_data), 32'(exp));
            chk("rsp_ready_blocked", 32'(req_ready), 0);
            next_cycle();
        end
        rsp_ready = 1'b0;
        chk("stat_cnt", stat_cnt, ref_stats());
    endtask

    initial begin
        req_valid = 4'hF;
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_data", 32'(rsp_data), 0);
        chk("rst_stat", stat_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = '0;

        txn(4'b0001, 16'h0005, 16'h0009, 8'b01, 0);
        txn(4'b0001, 16'h0005, 16'h0009, 8'b10, 0);
        txn(4'b0001, 16'h0005, 16'h0009, 8'b11, 0);
        txn(4'b0001, 16'h0007, 16'h0007, 8'b00, 0);

        for (int i = 0; i < 6; i++) txn(4'hF, 16'($urandom), 16'($urandom), 8'($urandom), 0);

        txn(4'b0010, 16'h00C0, 16'h0030, 8'b1100, 5);

        // reset dropped during EXEC: no response may follow and priority restarts at 0
        req_valid = 4'b0010; req_x = 16'h0050; req_y = 16'h0010; req_s = 8'h0C;
        @(negedge clk);
        chk("pre_rst_grant", 32'(req_ready), 32'(1) << ref_win(4'b0010));
        next_cycle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_ready", 32'(req_ready), 0);
        chk("midrst_stat", stat_cnt, 0);
        ref_reset();
        next_cycle();
        rst_n = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(rsp_valid), 0);
            next_cycle();
        end
        txn(4'b0101, 16'h1234, 16'h4321, 8'hFF, 0);
        txn(4'b0101, 16'h1234, 16'h4321, 8'hFF, 0);

        for (int i = 0; i < 200; i++)
            txn(4'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

        for (int i = 0; i < 300; i++)
            txn(4'b0100, 16'($urandom), 16'($urandom), 8'($urandom), 0);
        chk("stat_sat_final", stat_cnt, ref_stats());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
